// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Burst sequencer for an external 4-bit LFSR. It loads a seed,
//               steps the LFSR once per value, and presents each value on a
//               valid/ready output port until the requested count is done.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       seed_in,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  input  logic [3:0]       lfsr_state,
  output logic             lfsr_sel,
  output logic [3:0]       lfsr_seed,
  output logic             out_valid,
  output logic [3:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             seed_fix
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_STEP = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [3:0]       c_seed_zero = 4'b0000;
  localparam logic [3:0]       c_seed_one  = 4'b0001;
  localparam logic [CNT_W-1:0] c_rem_zero  = '0;
  localparam logic [CNT_W-1:0] c_rem_one   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_rem;
  logic [3:0]       r_seed;
  logic             r_sel;
  logic             r_valid;
  logic [3:0]       r_data;
  logic             r_busy;
  logic             r_done;
  logic             r_fix;

  // Sequencer FSM with registered outputs; abort overrides any transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= c_rem_zero;
      r_seed  <= c_seed_one;
      r_sel   <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 4'b0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fix   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sel <= 1'b0;
          // A zero-length request is dropped without touching any state.
          if (start && (count != c_rem_zero)) begin
            // An all-zero seed would lock the LFSR, so it is replaced.
            r_seed  <= (seed_in == c_seed_zero) ? c_seed_one : seed_in;
            r_fix   <= (seed_in == c_seed_zero);
            r_rem   <= count;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_sel   <= 1'b1;
          r_state <= S_STEP;
        end
        S_STEP: begin
          r_sel   <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // First WAIT cycle captures the freshly shifted LFSR value.
          if (!r_valid) begin
            r_valid <= 1'b1;
            r_data  <= lfsr_state;
          end else if (out_ready) begin
            r_valid <= 1'b0;
            r_rem   <= r_rem - c_rem_one;
            if (r_rem == c_rem_one) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_sel   <= 1'b1;
              r_state <= S_STEP;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_sel   <= 1'b0;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
      if (abort && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_rem   <= c_rem_zero;
        r_sel   <= 1'b0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end
    end
  end

  // While waiting, the LFSR reloads its own value so it holds across stalls.
  assign lfsr_seed = (r_state == S_WAIT) ? lfsr_state : r_seed;
  assign lfsr_sel  = r_sel;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign busy      = r_busy;
  assign done      = r_done;
  assign seed_fix  = r_fix;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_seq_ctrl
// Description : Self-checking bench for lfsr_seq_ctrl with an attached 4-bit
//               LFSR (x^4 + x^3 + 1) and a sequence-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [3:0]       seed_in;
  logic [CNT_W-1:0] count;
  logic             abort;
  logic [3:0]       lfsr_q;
  logic             lfsr_sel;
  logic [3:0]       lfsr_seed;
  logic             out_valid;
  logic [3:0]       out_data;
  logic             out_ready;
  logic             busy;
  logic             done;
  logic             seed_fix;

  int checks = 0;
  int errors = 0;

  lfsr_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed_in    (seed_in),
    .count      (count),
    .abort      (abort),
    .lfsr_state (lfsr_q),
    .lfsr_sel   (lfsr_sel),
    .lfsr_seed  (lfsr_seed),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .seed_fix   (seed_fix)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External LFSR instance driven by the controller.
  always_ff @(posedge clk) begin
    if (lfsr_sel) lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    else          lfsr_q <= lfsr_seed;
  end

  // Reference: one LFSR shift as a mathematical step on the value.
  function automatic logic [3:0] nxt(input logic [3:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One burst: expected values are the n successive LFSR states after the
  // (substituted) seed; latency is 3 cycles to the first value, 2 after.
  task automatic do_burst(input logic [3:0] s, input int n, input int stall_k,
                          input int stall_len, input bit rnd, input int abort_k);
    logic [3:0] q[$];
    logic [3:0] v;
    int nn;
    int sl;
    v = (s == 4'd0) ? 4'd1 : s;
    for (int i = 0; i < n; i++) begin
      v = nxt(v);
      q.push_back(v);
    end
    @(negedge clk);
    start = 1'b1; seed_in = s; count = n[CNT_W-1:0]; out_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      nn = 0;
      do begin
        @(negedge clk);
        nn++;
        start = 1'b0;
      end while (!out_valid && nn < 20);
      check("latency", nn - 1, (k == 0) ? 3 : 2);
      if (!out_valid) return;
      check("data", out_data, q[k]);
      check("busy_run", busy, 1'b1);
      if (k == 0) check("seed_fix", seed_fix, (s == 4'd0));
      if (k == abort_k) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", out_valid, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (3) begin
          @(negedge clk);
          check("abort_idle_done", done, 1'b0);
          check("abort_idle_busy", busy, 1'b0);
        end
        return;
      end
      sl = rnd ? int'($urandom_range(0, 3)) : ((k == stall_k) ? stall_len : 0);
      if (sl > 0) begin
        out_ready = 1'b0;
        repeat (sl) begin
          @(negedge clk);
          check("stall_valid", out_valid, 1'b1);
          check("stall_data", out_data, q[k]);
          check("stall_lfsr", lfsr_q, q[k]);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_valid", out_valid, 1'b0);
    @(negedge clk);
    check("done_clear", done, 1'b0);
    check("busy_end", busy, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; seed_in = 4'd0; count = '0;
    abort = 1'b0; out_ready = 1'b0; lfsr_q = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 1'b0);
    check("rst_data", out_data, 4'd0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fix", seed_fix, 1'b0);
    check("rst_sel", lfsr_sel, 1'b0);
    check("rst_seed", lfsr_seed, 4'b0001);

    // Basic burst, then the same burst with a 5-cycle stall on value 2.
    do_burst(4'hF, 3, -1, 0, 1'b0, -1);
    do_burst(4'hF, 3, 1, 5, 1'b0, -1);
    // Zero seed is substituted.
    do_burst(4'h0, 2, -1, 0, 1'b0, -1);
    check("fix_sticky", seed_fix, 1'b1);
    // Abort on value 2 of a 4-value burst.
    do_burst(4'h9, 4, -1, 0, 1'b0, 1);
    // Zero count is ignored.
    @(negedge clk);
    start = 1'b1; seed_in = 4'h5; count = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("cnt0_busy", busy, 1'b0);
      check("cnt0_valid", out_valid, 1'b0);
    end
    // Maximum count, no wrap.
    do_burst(4'(int'($urandom_range(1, 15))), 15, -1, 0, 1'b0, -1);
    // start while busy is ignored: burst of 2, pulse start mid-burst.
    fork
      do_burst(4'h3, 2, -1, 0, 1'b0, -1);
      begin
        repeat (4) @(negedge clk);
        start = 1'b1; seed_in = 4'hA; count = 4'd7;
        @(negedge clk);
        start = 1'b0;
      end
    join
    // Randomized bursts with random stalls.
    for (int b = 0; b < 8; b++) begin
      do_burst(4'($urandom_range(0, 15)), int'($urandom_range(1, 15)), -1, 0, 1'b1, -1);
    end
    // Reset asserted during STEP.
    @(negedge clk);
    start = 1'b1; seed_in = 4'hF; count = 4'd3; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 4'd0);
    check("mid_rst_sel", lfsr_sel, 1'b0);
    check("mid_rst_seed", lfsr_seed, 4'b0001);
    check("mid_rst_fix", seed_fix, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_burst(4'hF, 1, -1, 0, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_seq_ctrl.md
LFSR_SEQ_CTRL -- requirements
Module: lfsr_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the requested-value count.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port start  input  1  request a burst; sampled only in IDLE.
REQ-005 SHALL have port seed_in  input  4  seed for the burst, captured with start.
REQ-006 SHALL have port count  input  CNT_W  number of values to deliver, captured with start.
REQ-007 SHALL have port abort  input  1  terminate burst, return to IDLE.
REQ-008 SHALL have port lfsr_state  input  4  current state of the external 4-bit lfsr instance.
REQ-009 SHALL have port lfsr_sel  output  1  lfsr mode: 0 = load lfsr_seed, 1 = shift.
REQ-010 SHALL have port lfsr_seed  output  4  value loaded into the lfsr when lfsr_sel=0.
REQ-011 SHALL have port out_valid  output  1  out_data holds a valid value.
REQ-012 SHALL have port out_data  output  4  delivered pseudo-random value.
REQ-013 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid=1.
REQ-014 SHALL have port busy  output  1  high in any state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse after the last accepted value.
REQ-016 SHALL have port seed_fix  output  1  sticky flag: last captured seed was 0 and was substituted.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, STEP, WAIT, DONE.
REQ-018 IDLE: lfsr_sel=0, lfsr_seed=held register; start=1 and count!=0 -> capture seed/count, go LOAD; start with count=0 -> ignored, stay IDLE.
REQ-019 Seed capture: seed_in=4'b0000 SHALL be replaced by 4'b0001 and seed_fix set; nonzero seed clears seed_fix.
REQ-020 LOAD (1 cycle): lfsr_sel=0, lfsr_seed=captured seed; next state STEP.
REQ-021 STEP (1 cycle): lfsr_sel=1 (lfsr advances one shift); next state WAIT.
REQ-022 WAIT: out_valid=1, out_data=lfsr_state; lfsr_sel=0 with lfsr_seed=lfsr_state so the lfsr holds its value while stalled.
REQ-023 WAIT with out_ready=1: remaining count decrements; remaining reaching 0 -> DONE, else -> STEP.
REQ-024 WAIT with out_ready=0: stay in WAIT; out_data SHALL remain stable.
REQ-025 DONE (1 cycle): done=1, out_valid=0; next state IDLE.
REQ-026 Latency: first out_valid 3 cycles after the edge sampling start; each subsequent value 2 cycles after the previous acceptance when out_ready stays high.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle, no done pulse, remaining cleared; abort has priority over out_ready.
REQ-028 start while busy SHALL be ignored.
REQ-029 Remaining counter SHALL be CNT_W bits; count=2^CNT_W-1 SHALL deliver exactly that many values without wrap.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, out_valid=0, out_data=0, done=0, busy=0, seed_fix=0, lfsr_sel=0, lfsr_seed=4'b0001, remaining=0, regardless of clk.
REQ-031 Reset asserted mid-burst SHALL discard the burst; after release the block accepts a new start normally.

Verification
REQ-032 rst low 2 cycles, release -> all outputs at REQ-030 values; lfsr_sel=0.
REQ-033 start, seed_in=4'b1111, count=3, out_ready=1 -> first out_valid 3 cycles after start, 3 values equal to successive lfsr model states after 1111, done pulse once, busy drops.
REQ-034 Same burst, out_ready low 5 cycles on second value -> out_valid and out_data stable for 5 cycles, lfsr_state unchanged, sequence identical to REQ-033.
REQ-035 start, seed_in=4'b0000, count=2 -> lfsr loaded with 4'b0001, seed_fix=1, two nonzero values delivered.
REQ-036 abort during WAIT of value 2 of count=4 -> IDLE next cycle, no done, busy=0; start with count=0 -> no activity.
REQ-037 rst pulsed low during STEP -> immediate REQ-030 state; subsequent start, seed 4'b1111, count=1 -> one correct value, done pulse.
